// File: rtl/common_pkg.sv
// Shared constants for the minimal RISC-V core: widths, fill word and the
// fixed boot image used by instruction_memory.
package common_pkg;

  localparam int INSTRUCTION_MEMORY_ADDRESS_WIDTH = 16;
  localparam int INSTRUCTION_WIDTH                = 32;
  localparam logic [INSTRUCTION_WIDTH-1:0] INSTRUCTION_MEMORY_FILL_WORD = 32'hDEADBEEF;

  // Word index -> boot image word; everything past the program is fill.
  function automatic logic [INSTRUCTION_WIDTH-1:0] boot_image_word(input int unsigned index);
    case (index)
      0:       boot_image_word = 32'h02103083;
      1:       boot_image_word = 32'hAFBFCFDF;
      2:       boot_image_word = 32'h7034EF55;
      3:       boot_image_word = 32'h11223344;
      default: boot_image_word = INSTRUCTION_MEMORY_FILL_WORD;
    endcase
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store with a zero-latency read port.
// Define INSTRUCTION_MEMORY_LOAD_EN to add a synchronous load port that rewrites the boot image.
module instruction_memory
  import common_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] instruction_address,
  output logic [INSTRUCTION_WIDTH-1:0]                instruction_data
`ifdef INSTRUCTION_MEMORY_LOAD_EN
  ,
  input  logic                                        load_enable,
  input  logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] load_address,
  input  logic [INSTRUCTION_WIDTH-1:0]                load_data
`endif
);

  localparam int AW      = INSTRUCTION_MEMORY_ADDRESS_WIDTH;
  localparam int INDEX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH = 2^AW still compares correctly.
  localparam logic [AW:0] DEPTH_LIMIT = DEPTH[AW:0];

  logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH];
  logic                         read_in_range;

  // Out-of-range addresses return the fill word rather than aliasing onto low words.
  assign read_in_range = ({1'b0, instruction_address} < DEPTH_LIMIT);

  always_comb begin
    instruction_data = INSTRUCTION_MEMORY_FILL_WORD;
    if (read_in_range) instruction_data = mem[instruction_address[INDEX_W-1:0]];
  end

`ifdef INSTRUCTION_MEMORY_LOAD_EN

  logic load_in_range;

  assign load_in_range = ({1'b0, load_address} < DEPTH_LIMIT);

  // Reset reloads the whole image asynchronously; loads outside the array are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= boot_image_word(i);
    end else if (load_enable && load_in_range) begin
      mem[load_address[INDEX_W-1:0]] <= load_data;
    end
  end

`else

  logic unused_ok;

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign mem[i] = boot_image_word(i);
  end

  // Pure ROM: clk and rst are kept on the port list for drop-in compatibility only.
  assign unused_ok = &{1'b0, clk, rst};

`endif

endmodule

// File: tb/tb_instruction_memory.sv
// Directed scoreboard bench for instruction_memory, covering both the ROM
// build and the INSTRUCTION_MEMORY_LOAD_EN build.
module tb_instruction_memory;

  localparam int DEPTH = 64;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [15:0] instruction_address;
  logic [31:0] instruction_data;
`ifdef INSTRUCTION_MEMORY_LOAD_EN
  logic        load_enable;
  logic [15:0] load_address;
  logic [31:0] load_data;
`endif

  int vectors;
  int miscompares;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] model_mem [DEPTH];

  instruction_memory #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .instruction_address (instruction_address),
    .instruction_data    (instruction_data)
`ifdef INSTRUCTION_MEMORY_LOAD_EN
    ,
    .load_enable         (load_enable),
    .load_address        (load_address),
    .load_data           (load_data)
`endif
  );

  // Clock runs only while clk_en is set; otherwise it is parked low.
  initial begin
    clk = 1'b0;
    forever #5 clk = clk_en ? ~clk : 1'b0;
  end

  function automatic void model_boot();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'hDEADBEEF;
    model_mem[0] = 32'h02103083;
    model_mem[1] = 32'hAFBFCFDF;
    model_mem[2] = 32'h7034EF55;
    model_mem[3] = 32'h11223344;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    if (int'(a) < DEPTH) return model_mem[int'(a)];
    return 32'hDEADBEEF;
  endfunction

  // Drive an address, queue the expected word, then compare 1 ns later.
  task automatic apply(input logic [15:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    instruction_address = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (instruction_data === e)
      else begin
        miscompares++;
        $error("FAIL %s addr=%h: observed %h expected %h", t, a, instruction_data, e);
      end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk_en      = 1'b0;
    rst         = 1'b1;
    instruction_address = 16'h0000;
`ifdef INSTRUCTION_MEMORY_LOAD_EN
    load_enable  = 1'b0;
    load_address = 16'h0000;
    load_data    = 32'h0;
`endif
    model_boot();

    // Reset state and image readout with no clock edges at all.
    #2;
    apply(16'h0000, 32'h02103083, "reset_word0");
    #2 rst = 1'b0;
    #2;
    apply(16'h0000, 32'h02103083, "image0"); #4;
    apply(16'h0001, 32'hAFBFCFDF, "image1"); #4;
    apply(16'h0002, 32'h7034EF55, "image2"); #4;
    apply(16'h0003, 32'h11223344, "image3"); #4;
    apply(16'h0004, 32'hDEADBEEF, "fill4");
    apply(16'h0005, 32'hDEADBEEF, "fill5");
    apply(16'd63,   32'hDEADBEEF, "fill_last");
    apply(16'd64,   32'hDEADBEEF, "oor_depth");
    apply(16'hFFFF, 32'hDEADBEEF, "oor_max");
    apply(16'd65,   32'hDEADBEEF, "oor_alias1");
    // Combinational latency with clk parked low.
    apply(16'h0003, 32'h11223344, "comb_3");
    apply(16'h0001, 32'hAFBFCFDF, "comb_1");

`ifdef INSTRUCTION_MEMORY_LOAD_EN
    clk_en = 1'b1;

    // Load word 5: old value before the edge, new value after.
    @(negedge clk);
    load_enable = 1'b1; load_address = 16'd5; load_data = 32'h00000013;
    apply(16'd5, 32'hDEADBEEF, "load5_before");
    @(posedge clk); model_mem[5] = 32'h00000013;
    apply(16'd5, model_read(16'd5), "load5_after");
    @(negedge clk);
    load_enable = 1'b0;

    // Write to 16'hFFFF is dropped; in-range words unchanged.
    @(negedge clk);
    load_enable = 1'b1; load_address = 16'hFFFF; load_data = 32'h00000000;
    @(posedge clk); #1;
    @(negedge clk);
    load_enable = 1'b0;
    for (int i = 0; i < 6; i++) apply(16'(i), model_read(16'(i)), "oor_write_keep");
    apply(16'd63, model_read(16'd63), "oor_write_keep63");
    apply(16'hFFFF, 32'hDEADBEEF, "oor_write_read");

    // Load word 0, then async reset between edges with load still requested.
    @(negedge clk);
    load_enable = 1'b1; load_address = 16'd0; load_data = 32'h12345678;
    @(posedge clk); model_mem[0] = 32'h12345678;
    apply(16'd0, model_read(16'd0), "load0_after");
    @(negedge clk);
    load_data = 32'hFFFFFFFF;
    #2 rst = 1'b1;
    model_boot();
    apply(16'd0, 32'h02103083, "async_rst_word0");
    apply(16'd5, 32'hDEADBEEF, "async_rst_word5");
    @(posedge clk);
    apply(16'd0, 32'h02103083, "rst_ignores_load");

    // First honoured load is at the first edge with rst low.
    @(negedge clk);
    rst = 1'b0; load_address = 16'd2; load_data = 32'hAAAA5555;
    apply(16'd2, 32'h7034EF55, "post_rst_before");
    @(posedge clk); model_mem[2] = 32'hAAAA5555;
    apply(16'd2, model_read(16'd2), "post_rst_load");
    @(negedge clk);
    load_enable = 1'b0;
    apply(16'd0, model_read(16'd0), "post_rst_word0");
    clk_en = 1'b0;
`else
    // ROM build: reset and clock activity change nothing.
    clk_en = 1'b1;
    #3 rst = 1'b1;
    apply(16'd0, 32'h02103083, "rom_rst_word0");
    #12 rst = 1'b0;
    #20;
    for (int i = 0; i < 6; i++) apply(16'(i), model_read(16'(i)), "rom_after_clk");
    apply(16'hFFFF, 32'hDEADBEEF, "rom_oor");
    clk_en = 1'b0;
`endif

    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
